line_buffer3: RTL

//  Upstream feeder for the 3x3 convolution stage. Accepts a raster-order,

---
 rtl/line_buffer3.sv | 71 +++++++
 1 files changed

// File: rtl/line_buffer3.sv
// line_buffer3: raster stream to vertically aligned pixel triples for a 3x3 stage
// Ports: clk/rst (async, active-high); in_valid, in_sof, in_pixel = raster input;
// out_valid, pix_top/pix_mid/pix_bot = rows r-2/r-1/r at out_col, out_row;
// frame_done pulses with the triple for the last pixel of the frame.
module line_buffer3 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  localparam int COL_BITS   = $clog2(IMG_WIDTH),
  localparam int ROW_BITS   = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic [COL_BITS-1:0]    out_col,
  output logic [ROW_BITS-1:0]    out_row,
  output logic                   frame_done
);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(IMG_HEIGHT - 1);
  logic [PIXEL_WIDTH-1:0] row_a [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] row_b [IMG_WIDTH];
  logic [COL_BITS-1:0] col, eff_col;
  logic [ROW_BITS-1:0] row, eff_row;
  logic last_col, last_row;
  // start of frame forces the beat to (0,0), abandoning any partial frame
  always_comb begin
    eff_col  = in_sof ? '0 : col;
    eff_row  = in_sof ? '0 : row;
    last_col = eff_col == COL_MAX;
    last_row = eff_row == ROW_MAX;
  end
  // row memories shift down one row per accepted beat; reads see pre-write data
  always_ff @(posedge clk) begin
    if (in_valid) begin
      row_a[eff_col] <= row_b[eff_col];
      row_b[eff_col] <= in_pixel;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pix_top    <= '0;
      pix_mid    <= '0;
      pix_bot    <= '0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      out_valid  <= in_valid && eff_row >= ROW_BITS'(2);
      frame_done <= in_valid && last_col && last_row;
      if (in_valid) begin
        col     <= last_col ? '0 : eff_col + 1'b1;
        row     <= last_col ? (last_row ? '0 : eff_row + 1'b1) : eff_row;
        pix_top <= row_a[eff_col];
        pix_mid <= row_b[eff_col];
        pix_bot <= in_pixel;
        out_col <= eff_col;
        out_row <= eff_row;
      end
    end
  end
endmodule
